// File: rtl/ram_dp_arbiter_4req.sv
// Four-requester arbiter in front of a true dual-port, write-first RAM.
// Grants up to two requests per cycle (port A, port B) in round-robin order,
// suppresses same-address collisions that involve a write, and routes the
// RAM's one-cycle-latency read data back to the requester that issued it.
module ram_dp_arbiter_4req #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr,
  input  logic [4*DATA_W-1:0]   din,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [4*DATA_W-1:0]   rdata,
  output logic                  ram_weA,
  output logic                  ram_weB,
  output logic [ADDR_W-1:0]     ram_addrA,
  output logic [ADDR_W-1:0]     ram_addrB,
  output logic [DATA_W-1:0]     ram_dinA,
  output logic [DATA_W-1:0]     ram_dinB,
  input  logic [DATA_W-1:0]     ram_doutA,
  input  logic [DATA_W-1:0]     ram_doutB,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic [ID_W-1:0]   ptr;
  logic              tag_a_valid, tag_b_valid;
  logic [ID_W-1:0]   tag_a_id, tag_b_id;
  logic [DATA_W-1:0] rdata_q [NREQ];

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] din_arr  [NREQ];
  logic              a_hit, b_hit, skip;
  logic [ID_W-1:0]   a_id, b_id, idx;
  logic              a_act, b_act;

  // Unpack the per-requester address and write-data buses
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_arr[i] = addr[i*ADDR_W +: ADDR_W];
      din_arr[i]  = din[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin scan: first requester wins A, next non-colliding one wins B
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    skip  = 1'b0;
    a_id  = '0;
    b_id  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!a_hit) begin
        if (req[idx]) begin
          a_hit = 1'b1;
          a_id  = idx;
        end
      end else if (!b_hit && req[idx]) begin
        if ((addr_arr[idx] == addr_arr[a_id]) && (we[idx] || we[a_id])) begin
          skip = 1'b1;
        end else begin
          b_hit = 1'b1;
          b_id  = idx;
        end
      end
    end
  end

  assign a_act = a_hit & ~rst;
  assign b_act = b_hit & ~rst;

  // Grant vector and RAM port drive; an idle port is driven to all zeros
  always_comb begin
    gnt       = '0;
    ram_weA   = 1'b0;
    ram_addrA = '0;
    ram_dinA  = '0;
    ram_weB   = 1'b0;
    ram_addrB = '0;
    ram_dinB  = '0;
    if (a_act) begin
      gnt[a_id] = 1'b1;
      ram_weA   = we[a_id];
      ram_addrA = addr_arr[a_id];
      ram_dinA  = din_arr[a_id];
    end
    if (b_act) begin
      gnt[b_id] = 1'b1;
      ram_weB   = we[b_id];
      ram_addrB = addr_arr[b_id];
      ram_dinB  = din_arr[b_id];
    end
  end

  // Pointer, read tags, held return data and saturating collision counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      tag_a_valid  <= 1'b0;
      tag_b_valid  <= 1'b0;
      tag_a_id     <= '0;
      tag_b_id     <= '0;
      conflict_cnt <= '0;
      for (int unsigned i = 0; i < NREQ; i++) rdata_q[i] <= '0;
    end else begin
      if (b_act)      ptr <= b_id + ID_W'(1);
      else if (a_act) ptr <= a_id + ID_W'(1);

      tag_a_valid <= a_act & ~we[a_id];
      tag_a_id    <= a_id;
      tag_b_valid <= b_act & ~we[b_id];
      tag_b_id    <= b_id;

      if (tag_a_valid) rdata_q[tag_a_id] <= ram_doutA;
      if (tag_b_valid) rdata_q[tag_b_id] <= ram_doutB;

      if (skip && (conflict_cnt != {CNT_W{1'b1}})) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // Return path: a tagged slot shows live RAM output, others hold their last value
  always_comb begin
    rvalid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rdata[i*DATA_W +: DATA_W] = rdata_q[i];
      if (tag_a_valid && (tag_a_id == ID_W'(i))) begin
        rvalid[i]                 = 1'b1;
        rdata[i*DATA_W +: DATA_W] = ram_doutA;
      end
      if (tag_b_valid && (tag_b_id == ID_W'(i))) begin
        rvalid[i]                 = 1'b1;
        rdata[i*DATA_W +: DATA_W] = ram_doutB;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_arbiter_4req.sv
// Bench for ram_dp_arbiter_4req: behavioural RAM, reference arbitration model,
// directed scenarios and randomized traffic.
module tb_ram_dp_arbiter_4req;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          req, we;
  logic [4*ADDR_W-1:0] addr;
  logic [4*DATA_W-1:0] din;
  logic [3:0]          gnt, rvalid;
  logic [4*DATA_W-1:0] rdata;
  logic                ram_weA, ram_weB;
  logic [ADDR_W-1:0]   ram_addrA, ram_addrB;
  logic [DATA_W-1:0]   ram_dinA, ram_dinB, ram_doutA, ram_doutB;
  logic [CNT_W-1:0]    conflict_cnt;
  logic                mem_clr;

  ram_dp_arbiter_4req #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_weA(ram_weA), .ram_weB(ram_weB),
    .ram_addrA(ram_addrA), .ram_addrB(ram_addrB),
    .ram_dinA(ram_dinA), .ram_dinB(ram_dinB),
    .ram_doutA(ram_doutA), .ram_doutB(ram_doutB),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Write-first true dual-port RAM with one-cycle read latency
  logic [DATA_W-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      if (ram_weA) ram[ram_addrA] <= ram_dinA;
      if (ram_weB) ram[ram_addrB] <= ram_dinB;
    end
    ram_doutA <= ram_weA ? ram_dinA : ram[ram_addrA];
    ram_doutB <= ram_weB ? ram_dinB : ram[ram_addrB];
  end

  // Reference state
  int                n_assert = 0;
  int                n_fail   = 0;
  int                ptr_m, cnt_m;
  logic [3:0]        exp_rv;
  logic [DATA_W-1:0] exp_rd [4];
  logic [DATA_W-1:0] mem_ref [1024];
  logic [3:0]        last_gnt, last_rv;
  logic [127:0]      last_rd;
  logic [CNT_W-1:0]  last_cnt;
  logic              last_weA;
  int                rv_count [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ga(input int i);
    return addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] gd(input int i);
    return din[i*DATA_W +: DATA_W];
  endfunction

  task automatic drive(input int i, input bit r, input bit w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[i] = r;
    we[i]  = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    din[i*DATA_W +: DATA_W]  = d;
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    cnt_m  = 0;
    exp_rv = '0;
    for (int i = 0; i < 4; i++) exp_rd[i] = '0;
  endtask

  // One clock: check every output at the negedge, then advance the model
  task automatic step();
    int a, b;
    bit skip;
    logic [3:0] eg, nrv;
    logic [ADDR_W+DATA_W:0] ea, eb;
    logic [127:0] erd;
    @(negedge clk);
    a = -1; b = -1; skip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int i = (ptr_m + k) % 4;
      if (req[i]) begin
        if (a < 0) a = i;
        else if (b < 0) begin
          if (ga(i) == ga(a) && (we[i] || we[a])) skip = 1'b1;
          else b = i;
        end
      end
    end
    eg = '0; ea = '0; eb = '0;
    if (a >= 0) begin eg[a] = 1'b1; ea = {we[a], ga(a), gd(a)}; end
    if (b >= 0) begin eg[b] = 1'b1; eb = {we[b], ga(b), gd(b)}; end
    for (int i = 0; i < 4; i++) erd[i*DATA_W +: DATA_W] = exp_rd[i];

    chk("gnt", 128'(gnt), 128'(eg));
    chk("portA", 128'({ram_weA, ram_addrA, ram_dinA}), 128'(ea));
    chk("portB", 128'({ram_weB, ram_addrB, ram_dinB}), 128'(eb));
    chk("rvalid", 128'(rvalid), 128'(exp_rv));
    chk("rdata", rdata, erd);
    chk("conflict_cnt", 128'(conflict_cnt), 128'(cnt_m));
    last_gnt = gnt; last_rv = rvalid; last_rd = rdata;
    last_cnt = conflict_cnt; last_weA = ram_weA;

    nrv = '0;
    if (a >= 0 && !we[a]) begin nrv[a] = 1'b1; exp_rd[a] = mem_ref[ga(a)]; end
    if (b >= 0 && !we[b]) begin nrv[b] = 1'b1; exp_rd[b] = mem_ref[ga(b)]; end
    if (a >= 0 && we[a]) mem_ref[ga(a)] = gd(a);
    if (b >= 0 && we[b]) mem_ref[ga(b)] = gd(b);
    exp_rv = nrv;
    if (skip && cnt_m < (2**CNT_W - 1)) cnt_m++;
    if (b >= 0)      ptr_m = (b + 1) % 4;
    else if (a >= 0) ptr_m = (a + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req = '0; we = '0; addr = '0; din = '0;
    for (int i = 0; i < 1024; i++) mem_ref[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_clr = 1'b0;

    // Randomized traffic over a small address window to provoke collisions
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        drive(i, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
              ADDR_W'($urandom_range(0, 7)), $urandom);
      step();
    end

    // Reset mid-cycle with reads in flight
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, ADDR_W'(32 + i), '0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_gnt", 128'(gnt), 128'(4'b0000));
    chk("rst_weA", 128'(ram_weA), 128'(1'b0));
    chk("rst_weB", 128'(ram_weB), 128'(1'b0));
    chk("rst_rvalid", 128'(rvalid), 128'(4'b0000));
    chk("rst_cnt", 128'(conflict_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();
    chk("post_rst_gnt", 128'(last_gnt), 128'(4'b0011));
    step();
    chk("post_rst_gnt2", 128'(last_gnt), 128'(4'b1100));

    // Write then read back through another requester
    req = '0; we = '0;
    drive(0, 1'b1, 1'b1, ADDR_W'(10'h155), 32'hDEADBEEF);
    step();
    chk("wr_gnt", 128'(last_gnt), 128'(4'b0001));
    chk("wr_weA", 128'(last_weA), 128'(1'b1));
    req = '0; we = '0;
    drive(2, 1'b1, 1'b0, ADDR_W'(10'h155), '0);
    step();
    chk("rd_gnt", 128'(last_gnt), 128'(4'b0100));
    req = '0;
    step();
    chk("rd_rvalid", 128'(last_rv), 128'(4'b0100));
    chk("rd_data", 128'(last_rd[64 +: 32]), 128'(32'hDEADBEEF));

    // Walk ptr to 1, then write/read collision on 0x3FF
    drive(3, 1'b1, 1'b0, ADDR_W'(5), '0);
    step();
    req = '0;
    drive(0, 1'b1, 1'b0, ADDR_W'(6), '0);
    step();
    req = '0; we = '0;
    drive(1, 1'b1, 1'b1, ADDR_W'(10'h3FF), 32'h12345678);
    drive(3, 1'b1, 1'b0, ADDR_W'(10'h3FF), '0);
    step();
    chk("col_gnt", 128'(last_gnt), 128'(4'b0010));
    chk("col_cnt_before", 128'(last_cnt), 128'(0));
    req[1] = 1'b0;
    step();
    chk("col_gnt3", 128'(last_gnt), 128'(4'b1000));
    chk("col_cnt_after", 128'(last_cnt), 128'(1));
    req = '0;
    step();
    chk("col_rvalid", 128'(last_rv), 128'(4'b1000));
    chk("col_data", 128'(last_rd[96 +: 32]), 128'(32'h12345678));

    // Same-address dual read (ptr=0)
    req = '0; we = '0;
    drive(0, 1'b1, 1'b0, ADDR_W'(10'h010), '0);
    drive(2, 1'b1, 1'b0, ADDR_W'(10'h010), '0);
    step();
    chk("dual_gnt", 128'(last_gnt), 128'(4'b0101));
    req = '0;
    step();
    chk("dual_rvalid", 128'(last_rv), 128'(4'b0101));
    chk("dual_same", 128'(last_rd[0 +: 32]), 128'(last_rd[64 +: 32]));
    chk("dual_cnt", 128'(last_cnt), 128'(1));

    // Fairness: bring ptr to 0, then all four read continuously
    drive(3, 1'b1, 1'b0, ADDR_W'(7), '0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(i, 1'b1, 1'b0, ADDR_W'(10'h100 + i), '0);
      rv_count[i] = 0;
    end
    for (int f = 0; f < 8; f++) begin
      step();
      chk("fair_gnt", 128'(last_gnt), (f % 2 == 0) ? 128'(4'b0011) : 128'(4'b1100));
      if (f > 0) for (int i = 0; i < 4; i++) rv_count[i] += int'(last_rv[i]);
    end
    req = '0;
    step();
    for (int i = 0; i < 4; i++) rv_count[i] += int'(last_rv[i]);
    for (int i = 0; i < 4; i++) chk("fair_rv_count", 128'(rv_count[i]), 128'(4));

    // Counter saturation under a continuous collision
    req = '0; we = '0;
    drive(1, 1'b1, 1'b1, ADDR_W'(10'h3FF), 32'h0BADF00D);
    drive(3, 1'b1, 1'b0, ADDR_W'(10'h3FF), '0);
    repeat (2**CNT_W + 5) step();
    req = '0;
    step();
    chk("sat_cnt", 128'(last_cnt), 128'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
